// File: rtl/ex_ctrl_if.sv
// ex_ctrl_if: bundles the ID, ALU, data-memory, writeback, redirect and trap
// signals around the execute-stage sequencer. The master modport is the
// ex_ctrl side; the slave modport is the surrounding core/environment.
interface ex_ctrl_if;
  logic        id_valid_in;
  logic        id_ready_out;
  logic [31:0] id_pc_in;
  logic [31:0] id_rs1_data_in;
  logic [31:0] id_rs2_data_in;
  logic [31:0] id_imm_in;
  logic [6:0]  id_opcode_in;
  logic [2:0]  id_funct3_in;
  logic [6:0]  id_funct7_in;
  logic [4:0]  id_rd_in;

  logic [31:0] alu_pc_out;
  logic [31:0] alu_rs1_data_out;
  logic [31:0] alu_rs2_data_out;
  logic [31:0] alu_imm_out;
  logic [6:0]  alu_opcode_out;
  logic [2:0]  alu_funct3_out;
  logic [6:0]  alu_funct7_out;
  logic [31:0] alu_jaddr_in;
  logic [31:0] alu_ram_addr_in;
  logic [31:0] alu_rd_data_in;
  logic        alu_jflag_in;

  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_wdata_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;

  logic        wb_valid_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic        redirect_valid_out;
  logic [31:0] redirect_pc_out;
  logic        trap_out;
  logic [1:0]  trap_cause_out;

  modport master (
    input  id_valid_in, id_pc_in, id_rs1_data_in, id_rs2_data_in, id_imm_in,
           id_opcode_in, id_funct3_in, id_funct7_in, id_rd_in,
           alu_jaddr_in, alu_ram_addr_in, alu_rd_data_in, alu_jflag_in,
           mem_ack_in, mem_rdata_in,
    output id_ready_out,
           alu_pc_out, alu_rs1_data_out, alu_rs2_data_out, alu_imm_out,
           alu_opcode_out, alu_funct3_out, alu_funct7_out,
           mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out,
           wb_valid_out, wb_rd_out, wb_data_out,
           redirect_valid_out, redirect_pc_out, trap_out, trap_cause_out
  );

  modport slave (
    output id_valid_in, id_pc_in, id_rs1_data_in, id_rs2_data_in, id_imm_in,
           id_opcode_in, id_funct3_in, id_funct7_in, id_rd_in,
           alu_jaddr_in, alu_ram_addr_in, alu_rd_data_in, alu_jflag_in,
           mem_ack_in, mem_rdata_in,
    input  id_ready_out,
           alu_pc_out, alu_rs1_data_out, alu_rs2_data_out, alu_imm_out,
           alu_opcode_out, alu_funct3_out, alu_funct7_out,
           mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out,
           wb_valid_out, wb_rd_out, wb_data_out,
           redirect_valid_out, redirect_pc_out, trap_out, trap_cause_out
  );
endinterface

// File: rtl/ex_ctrl.sv
// ex_ctrl: RV32I execute-stage sequencer. Latches one decoded instruction from
// ID, holds it in front of the combinational ALU for one EXEC cycle, then
// retires it as a writeback, a redirect, or a data-memory transaction.
// Optional feature macro: EX_MISALIGN_TRAP_EN (misaligned target/access traps).
// Without it, trap outputs are tied low and misaligned halfword/word accesses
// drop the sub-lane offset bits.
module ex_ctrl (
  input  logic      clk,
  input  logic      rst_n,
  ex_ctrl_if.master bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AL     = 7'b0110011;
  localparam logic [6:0] OP_ALI    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

  state_t      state;

  logic [31:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [6:0]  opcode_q, funct7_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;

  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [1:0]  off_q;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic [1:0]  size_n, off_raw_n, eff_off_n;
  logic [31:0] jump_pc_n;
  logic        trap_hit_n;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane select by byte offset, then sign- or zero-extend per funct3.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic        [31:0] r;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Lane geometry of the current memory access and the redirect target.
  always_comb begin
    size_n    = funct3_q[1:0];
    off_raw_n = bus.alu_ram_addr_in[1:0];
    case (size_n)
      2'b00:   eff_off_n = off_raw_n;
      2'b01:   eff_off_n = {off_raw_n[1], 1'b0};
      default: eff_off_n = 2'b00;
    endcase
    jump_pc_n = (opcode_q == OP_BRANCH) ? bus.alu_jaddr_in
                                        : {bus.alu_jaddr_in[31:1], 1'b0};
  end

`ifdef EX_MISALIGN_TRAP_EN
  logic       trap_q;
  logic [1:0] trap_cause_q, trap_cause_n;
  logic       misaligned_n;

  // Classify EXEC-cycle misalignment; a hit cancels the instruction.
  always_comb begin
    trap_hit_n   = 1'b0;
    trap_cause_n = 2'd0;
    misaligned_n = ((size_n == 2'b01) && off_raw_n[0]) || (size_n[1] && (off_raw_n != 2'b00));
    case (opcode_q)
      OP_BRANCH:       if (bus.alu_jflag_in && bus.alu_jaddr_in[1]) trap_hit_n = 1'b1;
      OP_JAL, OP_JALR: if (bus.alu_jaddr_in[1]) trap_hit_n = 1'b1;
      OP_LOAD:         if (misaligned_n) begin trap_hit_n = 1'b1; trap_cause_n = 2'd1; end
      OP_STORE:        if (misaligned_n) begin trap_hit_n = 1'b1; trap_cause_n = 2'd2; end
      default:         trap_hit_n = 1'b0;
    endcase
  end

  // Single-cycle trap pulse with its cause held alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q       <= 1'b0;
      trap_cause_q <= 2'd0;
    end else begin
      trap_q <= (state == EXEC) && trap_hit_n;
      if ((state == EXEC) && trap_hit_n) trap_cause_q <= trap_cause_n;
    end
  end

  assign bus.trap_out       = trap_q;
  assign bus.trap_cause_out = trap_cause_q;
`else
  assign trap_hit_n         = 1'b0;
  assign bus.trap_out       = 1'b0;
  assign bus.trap_cause_out = 2'd0;
`endif

  // Sequencer: accept in IDLE, resolve in EXEC, hold the bus in MEM until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pc_q             <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      imm_q            <= '0;
      opcode_q         <= '0;
      funct3_q         <= '0;
      funct7_q         <= '0;
      rd_q             <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_be_q         <= '0;
      mem_wdata_q      <= '0;
      off_q            <= '0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      wb_valid_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.id_valid_in) begin
            pc_q     <= bus.id_pc_in;
            rs1_q    <= bus.id_rs1_data_in;
            rs2_q    <= bus.id_rs2_data_in;
            imm_q    <= bus.id_imm_in;
            opcode_q <= bus.id_opcode_in;
            funct3_q <= bus.id_funct3_in;
            funct7_q <= bus.id_funct7_in;
            rd_q     <= bus.id_rd_in;
            state    <= EXEC;
          end
        end
        EXEC: begin
          state <= IDLE;
          if (!trap_hit_n) begin
            case (opcode_q)
              OP_LOAD, OP_STORE: begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= (opcode_q == OP_STORE);
                mem_addr_q  <= {bus.alu_ram_addr_in[31:2], 2'b00};
                mem_be_q    <= lane_mask(size_n, eff_off_n);
                mem_wdata_q <= (opcode_q == OP_STORE) ? store_lanes(size_n, rs2_q) : 32'd0;
                off_q       <= eff_off_n;
                state       <= MEM;
              end
              OP_BRANCH: begin
                if (bus.alu_jflag_in) begin
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= jump_pc_n;
                end
              end
              OP_JAL, OP_JALR: begin
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= jump_pc_n;
                if (rd_q != 5'd0) begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd_q;
                  wb_data_q  <= bus.alu_rd_data_in;
                end
              end
              OP_AL, OP_ALI, OP_LUI, OP_AUIPC: begin
                if (rd_q != 5'd0) begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd_q;
                  wb_data_q  <= bus.alu_rd_data_in;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
        MEM: begin
          if (bus.mem_ack_in) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
            if (!mem_we_q && (rd_q != 5'd0)) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= load_ext(funct3_q, off_q, bus.mem_rdata_in);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.id_ready_out       = (state == IDLE);
  assign bus.alu_pc_out         = pc_q;
  assign bus.alu_rs1_data_out   = rs1_q;
  assign bus.alu_rs2_data_out   = rs2_q;
  assign bus.alu_imm_out        = imm_q;
  assign bus.alu_opcode_out     = opcode_q;
  assign bus.alu_funct3_out     = funct3_q;
  assign bus.alu_funct7_out     = funct7_q;
  assign bus.mem_req_out        = mem_req_q;
  assign bus.mem_we_out         = mem_we_q;
  assign bus.mem_addr_out       = mem_addr_q;
  assign bus.mem_be_out         = mem_be_q;
  assign bus.mem_wdata_out      = mem_wdata_q;
  assign bus.wb_valid_out       = wb_valid_q;
  assign bus.wb_rd_out          = wb_rd_q;
  assign bus.wb_data_out        = wb_data_q;
  assign bus.redirect_valid_out = redirect_valid_q;
  assign bus.redirect_pc_out    = redirect_pc_q;

endmodule

// File: tb/tb_ex_ctrl.sv
// tb_ex_ctrl: directed bench for ex_ctrl with a small combinational ALU model,
// a scoreboard queue of expected retire pulses and a decoupled monitor.
module tb_ex_ctrl;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AL     = 7'b0110011;
  localparam logic [6:0] OP_ALI    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_ctrl_if bus();
  ex_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic        trap;
    logic [1:0]  cause;
    int          at;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input logic wb, input logic [4:0] rd, input logic [31:0] data,
                            input logic rv, input logic [31:0] rpc,
                            input logic trap, input logic [1:0] cause, input int at);
    exp_t e;
    e.wb = wb; e.rd = rd; e.data = data; e.rv = rv; e.rpc = rpc;
    e.trap = trap; e.cause = cause; e.at = at;
    sb.push_back(e);
  endtask

  // Minimal RV32I ALU standing in for the real one.
  always_comb begin
    bus.alu_rd_data_in  = 32'd0;
    bus.alu_jaddr_in    = bus.alu_pc_out + bus.alu_imm_out;
    bus.alu_ram_addr_in = bus.alu_rs1_data_out + bus.alu_imm_out;
    bus.alu_jflag_in    = 1'b0;
    case (bus.alu_opcode_out)
      OP_ALI:        bus.alu_rd_data_in = bus.alu_rs1_data_out + bus.alu_imm_out;
      OP_AL:         bus.alu_rd_data_in = bus.alu_rs1_data_out + bus.alu_rs2_data_out;
      OP_LUI:        bus.alu_rd_data_in = bus.alu_imm_out;
      OP_AUIPC:      bus.alu_rd_data_in = bus.alu_pc_out + bus.alu_imm_out;
      OP_JAL:        bus.alu_rd_data_in = bus.alu_pc_out + 32'd4;
      OP_JALR: begin
        bus.alu_rd_data_in = bus.alu_pc_out + 32'd4;
        bus.alu_jaddr_in   = bus.alu_rs1_data_out + bus.alu_imm_out;
      end
      OP_BRANCH: begin
        if (bus.alu_funct3_out == 3'b000) bus.alu_jflag_in = (bus.alu_rs1_data_out == bus.alu_rs2_data_out);
        if (bus.alu_funct3_out == 3'b001) bus.alu_jflag_in = (bus.alu_rs1_data_out != bus.alu_rs2_data_out);
      end
      default: bus.alu_rd_data_in = 32'd0;
    endcase
  end

  // Monitor: every retire pulse must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (bus.wb_valid_out || bus.redirect_valid_out || bus.trap_out)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, bus.wb_valid_out, bus.redirect_valid_out, bus.trap_out}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.at));
        check("wb_valid", 32'(bus.wb_valid_out), 32'(e.wb));
        if (e.wb) begin
          check("wb_rd", 32'(bus.wb_rd_out), 32'(e.rd));
          check("wb_data", bus.wb_data_out, e.data);
        end
        check("redirect_valid", 32'(bus.redirect_valid_out), 32'(e.rv));
        if (e.rv) check("redirect_pc", bus.redirect_pc_out, e.rpc);
        check("trap", 32'(bus.trap_out), 32'(e.trap));
        if (e.trap) check("trap_cause", 32'(bus.trap_cause_out), 32'(e.cause));
        check("ready_on_retire", 32'(bus.id_ready_out), 32'd1);
      end
    end
  end

  // Present one instruction at a negedge; returns at the EXEC-cycle negedge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, output int t0);
    check("ready_before_issue", 32'(bus.id_ready_out), 32'd1);
    t0                 = cyc;
    bus.id_opcode_in   = op;
    bus.id_funct3_in   = f3;
    bus.id_funct7_in   = 7'd0;
    bus.id_rd_in       = rd;
    bus.id_pc_in       = pc;
    bus.id_rs1_data_in = rs1;
    bus.id_rs2_data_in = rs2;
    bus.id_imm_in      = imm;
    bus.id_valid_in    = 1'b1;
    @(posedge clk);
    #1 bus.id_valid_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_mem(input string tag, input logic [31:0] addr, input logic [3:0] be,
                           input logic we, input logic [31:0] wdata, input logic chk_wdata);
    check({tag, "_req"},  32'(bus.mem_req_out), 32'd1);
    check({tag, "_addr"}, bus.mem_addr_out, addr);
    check({tag, "_be"},   32'(bus.mem_be_out), 32'(be));
    check({tag, "_we"},   32'(bus.mem_we_out), 32'(we));
    if (chk_wdata) check({tag, "_wdata"}, bus.mem_wdata_out, wdata);
  endtask

  task automatic ack(input logic [31:0] rdata);
    bus.mem_ack_in   = 1'b1;
    bus.mem_rdata_in = rdata;
    @(negedge clk);
    bus.mem_ack_in   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0;
    bus.id_valid_in = 1'b0; bus.id_pc_in = '0; bus.id_rs1_data_in = '0; bus.id_rs2_data_in = '0;
    bus.id_imm_in = '0; bus.id_opcode_in = '0; bus.id_funct3_in = '0; bus.id_funct7_in = '0;
    bus.id_rd_in = '0; bus.mem_ack_in = 1'b0; bus.mem_rdata_in = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.id_ready_out), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req_out), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid_out), 32'd0);
    check("rst_redirect", 32'(bus.redirect_valid_out), 32'd0);
    check("rst_trap", 32'(bus.trap_out), 32'd0);
    check("rst_alu_pc", bus.alu_pc_out, 32'd0);
    check("rst_mem_be", 32'(bus.mem_be_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI x5 = 7 + 3
    issue(OP_ALI, 3'b000, 5'd5, 32'h0, 32'd7, 32'd0, 32'd3, t0);
    expect_evt(1'b1, 5'd5, 32'd10, 1'b0, 32'd0, 1'b0, 2'd0, t0 + 2);
    @(negedge clk);

    // ADDI to x0: retires silently
    issue(OP_ALI, 3'b000, 5'd0, 32'h0, 32'd7, 32'd0, 32'd3, t0);
    @(negedge clk);
    check("rd0_no_wb", 32'(bus.wb_valid_out), 32'd0);

    // BEQ taken then not taken
    issue(OP_BRANCH, 3'b000, 5'd0, 32'h100, 32'd5, 32'd5, 32'h20, t0);
    expect_evt(1'b0, 5'd0, 32'd0, 1'b1, 32'h120, 1'b0, 2'd0, t0 + 2);
    @(negedge clk);
    issue(OP_BRANCH, 3'b000, 5'd0, 32'h100, 32'd5, 32'd6, 32'h20, t0);
    @(negedge clk);
    check("beq_not_taken", 32'(bus.redirect_valid_out), 32'd0);

    // JALR x1, 0x203(+0) from pc 0x40
    issue(OP_JALR, 3'b000, 5'd1, 32'h40, 32'h203, 32'd0, 32'd0, t0);
`ifdef EX_MISALIGN_TRAP_EN
    expect_evt(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 2'd0, t0 + 2);
`else
    expect_evt(1'b1, 5'd1, 32'h44, 1'b1, 32'h202, 1'b0, 2'd0, t0 + 2);
`endif
    @(negedge clk);

    // JAL x0 from 0x80 +0x10: redirect only
    issue(OP_JAL, 3'b000, 5'd0, 32'h80, 32'd0, 32'd0, 32'h10, t0);
    expect_evt(1'b0, 5'd0, 32'd0, 1'b1, 32'h90, 1'b0, 2'd0, t0 + 2);
    @(negedge clk);

    // LB at 0x1003, three wait cycles; a new ID request during MEM is ignored
    issue(OP_LOAD, 3'b000, 5'd6, 32'h0, 32'h1000, 32'd0, 32'd3, t0);
    @(negedge clk);
    check_mem("lb", 32'h1000, 4'b1000, 1'b0, 32'd0, 1'b0);
    bus.id_opcode_in = OP_ALI; bus.id_rd_in = 5'd9; bus.id_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lb_wait_req", 32'(bus.mem_req_out), 32'd1);
      check("lb_wait_addr", bus.mem_addr_out, 32'h1000);
    end
    bus.id_valid_in = 1'b0;
    expect_evt(1'b1, 5'd6, 32'hFFFF_FF80, 1'b0, 32'd0, 1'b0, 2'd0, t0 + 6);
    ack(32'h80FF_FF11);
    check("lb_req_release", 32'(bus.mem_req_out), 32'd0);

    // LH at 0x1002 (sign-extended upper half), immediate ack
    issue(OP_LOAD, 3'b001, 5'd7, 32'h0, 32'h1000, 32'd0, 32'd2, t0);
    @(negedge clk);
    check_mem("lh", 32'h1000, 4'b1100, 1'b0, 32'd0, 1'b0);
    expect_evt(1'b1, 5'd7, 32'hFFFF_80FF, 1'b0, 32'd0, 1'b0, 2'd0, t0 + 3);
    ack(32'h80FF_FF11);

    // LBU at 0x1001 (zero-extended)
    issue(OP_LOAD, 3'b100, 5'd8, 32'h0, 32'h1000, 32'd0, 32'd1, t0);
    @(negedge clk);
    check_mem("lbu", 32'h1000, 4'b0010, 1'b0, 32'd0, 1'b0);
    expect_evt(1'b1, 5'd8, 32'h0000_00FF, 1'b0, 32'd0, 1'b0, 2'd0, t0 + 3);
    ack(32'h80FF_FF11);

    // SW at 0x2000: no writeback
    issue(OP_STORE, 3'b010, 5'd0, 32'h0, 32'h2000, 32'hDEAD_BEEF, 32'd0, t0);
    @(negedge clk);
    check_mem("sw", 32'h2000, 4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b1);
    ack(32'd0);
    check("sw_req_release", 32'(bus.mem_req_out), 32'd0);

`ifdef EX_MISALIGN_TRAP_EN
    // LW at 0x3002 traps with cause 1 and never touches memory
    issue(OP_LOAD, 3'b010, 5'd8, 32'h0, 32'h3000, 32'd0, 32'd2, t0);
    expect_evt(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 2'd1, t0 + 2);
    @(negedge clk);
    check("lw_mis_no_req", 32'(bus.mem_req_out), 32'd0);
    @(negedge clk);
    check("lw_mis_no_req2", 32'(bus.mem_req_out), 32'd0);
`else
    // LW at 0x3002: offset bits dropped, whole word returned
    issue(OP_LOAD, 3'b010, 5'd8, 32'h0, 32'h3000, 32'd0, 32'd2, t0);
    @(negedge clk);
    check_mem("lw_trunc", 32'h3000, 4'b1111, 1'b0, 32'd0, 1'b0);
    expect_evt(1'b1, 5'd8, 32'h1122_3344, 1'b0, 32'd0, 1'b0, 2'd0, t0 + 3);
    ack(32'h1122_3344);
`endif

    // SH at 0x2002, then reset before ack abandons the transaction
    issue(OP_STORE, 3'b001, 5'd0, 32'h0, 32'h2000, 32'h1234_ABCD, 32'd2, t0);
    @(negedge clk);
    check_mem("sh", 32'h2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req_out), 32'd0);
    check("rst_mid_ready", 32'(bus.id_ready_out), 32'd1);
    check("rst_mid_rs2", bus.alu_rs2_data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD after reset: 0x7FFFFFFF + 1
    issue(OP_AL, 3'b000, 5'd3, 32'h0, 32'h7FFF_FFFF, 32'd1, 32'd0, t0);
    expect_evt(1'b1, 5'd3, 32'h8000_0000, 1'b0, 32'd0, 1'b0, 2'd0, t0 + 2);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_ctrl.md
# ex_ctrl

Execute-stage sequencer for the RV32I core. Accepts one decoded instruction from ID over a valid/ready handshake, holds it stable in front of the combinational ALU, then retires it in one of three ways: register writeback, branch/jump redirect to IF, or a data-memory request/acknowledge transaction with load extension or store lane packing. Sits between the ID stage, the ALU and the data-RAM port.

## Interface
- No parameters. Width is fixed: XLEN = 32, 5-bit register index.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid_in  in  1  ID presents an instruction
- id_ready_out  out  1  ex_ctrl can accept
- id_pc_in, id_rs1_data_in, id_rs2_data_in, id_imm_in  in  32 each  decoded operands
- id_opcode_in  in  7; id_funct3_in  in  3; id_funct7_in  in  7; id_rd_in  in  5
- alu_pc_out, alu_rs1_data_out, alu_rs2_data_out, alu_imm_out  out  32 each; alu_opcode_out  out  7; alu_funct3_out  out  3; alu_funct7_out  out  7  latched operands to ALU
- alu_jaddr_in, alu_ram_addr_in, alu_rd_data_in  in  32; alu_jflag_in  in  1  ALU results
- mem_req_out  out  1; mem_we_out  out  1; mem_addr_out  out  32 (word aligned); mem_be_out  out  4; mem_wdata_out  out  32
- mem_ack_in  in  1; mem_rdata_in  in  32
- wb_valid_out  out  1; wb_rd_out  out  5; wb_data_out  out  32
- redirect_valid_out  out  1; redirect_pc_out  out  32
- trap_out  out  1; trap_cause_out  out  2  (present only with EX_MISALIGN_TRAP_EN)

## Operation
- States: IDLE, EXEC, MEM. id_ready_out = (state == IDLE).
- IDLE: on id_valid_in & id_ready_out latch all id_* fields into the ALU-facing registers; go EXEC. id_valid_in in other states is ignored.
- EXEC (one cycle, ALU settles combinationally):
  - LOAD (0000011) / STORE (0100011): register mem_addr_out = {alu_ram_addr_in[31:2],2'b00}, byte offset, size; go MEM.
  - BRANCH (1100011): if alu_jflag_in, pulse redirect with alu_jaddr_in; no writeback. Go IDLE.
  - JAL (1101111) / JALR (1100111): pulse redirect; redirect_pc_out = alu_jaddr_in with bit 0 cleared; writeback alu_rd_data_in (pc+4). Go IDLE.
  - AL, ALI, LUI, AUIPC: writeback alu_rd_data_in. Go IDLE.
  - Any other opcode: no side effect, go IDLE.
  - Writeback suppressed when rd == 0.
- MEM: mem_req_out = 1, address/be/wdata/we held stable until mem_ack_in sampled high; then go IDLE.
  - Store: SB be = 0001 << off, wdata = {4{rs2[7:0]}}; SH be = 0011 << off, wdata = {2{rs2[15:0]}}; SW be = 1111, wdata = rs2.
  - Load: be as above, we = 0; on ack select lane by offset, sign-extend (LB, LH) or zero-extend (LBU, LHU), LW passthrough; writeback unless rd == 0.
- wb_valid_out, redirect_valid_out, trap_out: single-cycle registered pulses.

## Timing
- Reset: state IDLE; every output 0 except id_ready_out = 1; all latched operands 0. Reset during MEM drops mem_req_out immediately; the transaction is abandoned.
- Handshake at edge N → EXEC during cycle N+1 → wb/redirect pulse during cycle N+2, id_ready_out high in N+2. Throughput: one non-memory instruction per 2 cycles.
- Memory: mem_req_out rises in cycle N+2; ack sampled in that same cycle gives load wb_valid_out in N+3. Each extra wait cycle adds one.
- Redirect and writeback for JAL/JALR pulse in the same cycle.

## Configuration
- EX_MISALIGN_TRAP_EN defined: in EXEC, a taken redirect with target[1] = 1 (cause 2'd0), a load misaligned for its size (cause 2'd1), or a store misaligned for its size (cause 2'd2) pulses trap_out with trap_cause_out. The instruction's writeback, redirect and memory request are suppressed, and the block returns to IDLE.
- Undefined: no checks. trap_out and trap_cause_out are tied 0. Misaligned halfword/word accesses use the address truncated to the lane (offset bits beyond size ignored).

## Test plan
- Reset release, then ADDI rd=5, rs1=7, imm=3: wb_valid_out pulses 2 cycles after the handshake, with wb_rd_out = 5 and wb_data_out = 10; id_ready_out is high in that same cycle.
- BEQ pc=0x100, imm=0x20, rs1 = rs2: redirect_pc_out = 0x120, no wb; with rs1 ≠ rs2, no redirect.
- JALR rd=1, rs1=0x203, imm=0, pc=0x40: redirect_pc_out = 0x202 and wb_data_out = 0x44 in the same cycle (macro off).
- LB at address 0x1003 with mem_rdata_in = 0x80FF_FF11 and ack after 3 wait cycles: mem_be_out = 1000, wb_data_out = 0xFFFF_FF80.
- SH rs2 = 0x1234_ABCD at 0x2002: be = 1100, wdata = 0xABCD_ABCD; assert rst_n low before ack and confirm mem_req_out drops at once and id_ready_out = 1.
- Macro on, LW at 0x3002: trap_out pulses with cause 1, and no mem_req_out or wb occurs.
